// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a class/op/register/immediate request into
// a 32-bit instruction word behind a one-deep valid/ready output register.
module instr_encoder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_class,
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic [15:0] o_count
);

  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_IALU   = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_shift;
  logic        accept;

  assign o_ready = ~o_valid | i_ready;
  assign accept  = i_valid & o_ready;

  // Decode the request into funct fields, legality and the packed word.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    funct3    = '0;
    funct7    = '0;
    is_shift  = 1'b0;
    case (i_class)
      CLS_R: begin
        case (i_op)
          4'd0: funct3 = 3'b000;
          4'd1: begin funct3 = 3'b000; funct7 = F7_ALT; end
          4'd2: funct3 = 3'b001;
          4'd3: funct3 = 3'b010;
          4'd4: funct3 = 3'b011;
          4'd5: funct3 = 3'b100;
          4'd6: begin funct3 = 3'b101; funct7 = F7_ALT; end
          4'd7: funct3 = 3'b101;
          4'd8: funct3 = 3'b110;
          4'd9: funct3 = 3'b111;
          default: enc_legal = 1'b0;
        endcase
        enc_word = {funct7, i_rs2, i_rs1, funct3, i_rd, OPC_R};
      end
      CLS_IALU: begin
        case (i_op)
          4'd0: funct3 = 3'b000;
          4'd1: begin funct3 = 3'b001; is_shift = 1'b1; end
          4'd2: funct3 = 3'b010;
          4'd3: funct3 = 3'b011;
          4'd4: funct3 = 3'b100;
          4'd5: begin funct3 = 3'b101; is_shift = 1'b1; end
          4'd6: begin funct3 = 3'b101; is_shift = 1'b1; funct7 = F7_ALT; end
          4'd7: funct3 = 3'b110;
          4'd8: funct3 = 3'b111;
          default: enc_legal = 1'b0;
        endcase
        if (is_shift && (i_imm[11:5] != 7'd0))
          enc_legal = 1'b0;
        enc_word = is_shift ? {funct7, i_imm[4:0], i_rs1, funct3, i_rd, OPC_IALU}
                            : {i_imm[11:0], i_rs1, funct3, i_rd, OPC_IALU};
      end
      CLS_LOAD: begin
        case (i_op)
          4'd0: funct3 = 3'b000;
          4'd1: funct3 = 3'b001;
          4'd2: funct3 = 3'b010;
          4'd3: funct3 = 3'b100;
          4'd4: funct3 = 3'b101;
          default: enc_legal = 1'b0;
        endcase
        enc_word = {i_imm[11:0], i_rs1, funct3, i_rd, OPC_LOAD};
      end
      CLS_STORE: begin
        if (i_op > 4'd2)
          enc_legal = 1'b0;
        funct3 = i_op[2:0];
        enc_word = {i_imm[11:5], i_rs2, i_rs1, funct3, i_imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        case (i_op)
          4'd0: funct3 = 3'b000;
          4'd1: funct3 = 3'b001;
          4'd2: funct3 = 3'b100;
          4'd3: funct3 = 3'b101;
          4'd4: funct3 = 3'b110;
          4'd5: funct3 = 3'b111;
          default: enc_legal = 1'b0;
        endcase
        if (i_imm[0])
          enc_legal = 1'b0;
        enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, funct3,
                    i_imm[4:1], i_imm[11], OPC_BRANCH};
      end
      CLS_JAL: begin
        enc_legal = (i_op == 4'd0) && !i_imm[0];
        enc_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
      end
      CLS_JALR: begin
        enc_legal = (i_op == 4'd0);
        enc_word  = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR};
      end
      CLS_LUI: begin
        enc_legal = (i_op == 4'd0);
        enc_word  = {i_imm[31:12], i_rd, OPC_LUI};
      end
      CLS_AUIPC: begin
        enc_legal = (i_op == 4'd0);
        enc_word  = {i_imm[31:12], i_rd, OPC_AUIPC};
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // Output register: an illegal request is consumed like a legal one but only
  // raises o_err; o_ready high means any held word is leaving this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_instr <= '0;
      o_err   <= 1'b0;
      o_count <= '0;
    end else begin
      o_err <= accept & ~enc_legal;
      if (accept && enc_legal) begin
        o_valid <= 1'b1;
        o_instr <= enc_word;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
      if (o_valid && i_ready && (o_count != 16'hFFFF))
        o_count <= o_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings and handshake
// cases, then randomized requests against a field-level reference model.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  cls;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        down_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  int nops   [0:8] = '{10, 9, 5, 3, 6, 1, 1, 1, 1};
  int opcode [0:8] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h67, 'h37, 'h17};
  int r_f3   [0:9] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int i_f3   [0:8] = '{0, 1, 2, 3, 4, 5, 5, 6, 7};
  int ld_f3  [0:4] = '{0, 1, 2, 4, 5};
  int br_f3  [0:5] = '{0, 1, 4, 5, 6, 7};

  bit          m_valid;
  logic [31:0] m_instr;
  bit          m_err;
  int          m_count;

  instr_encoder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_class (cls),
    .i_op    (op),
    .i_rd    (rd),
    .i_rs1   (rs1),
    .i_rs2   (rs2),
    .i_imm   (imm),
    .o_valid (out_valid),
    .i_ready (down_ready),
    .o_instr (instr),
    .o_err   (err),
    .o_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder: builds the word as a sum of shifted instruction fields.
  function automatic void ref_encode(input int c, input int o, input int d, input int s1,
                                     input int s2, input logic [31:0] im,
                                     output bit legal, output logic [31:0] word);
    bit shift;
    int opc;
    word = '0;
    legal = (c >= 0) && (c <= 8);
    if (!legal) return;
    legal = (o < nops[c]);
    if (!legal) return;
    shift = (c == 1) && (o == 1 || o == 5 || o == 6);
    if (shift && fld(im, 11, 5) != 0) legal = 0;
    if ((c == 4 || c == 5) && im[0]) legal = 0;
    if (!legal) return;
    opc = opcode[c];
    case (c)
      0: word = (((o == 1 || o == 6) ? 32 : 0) << 25) + (s2 << 20) + (s1 << 15)
                + (r_f3[o] << 12) + (d << 7) + opc;
      1: word = ((shift ? (fld(im, 4, 0) + ((o == 6) ? 1024 : 0)) : fld(im, 11, 0)) << 20)
                + (s1 << 15) + (i_f3[o] << 12) + (d << 7) + opc;
      2: word = (fld(im, 11, 0) << 20) + (s1 << 15) + (ld_f3[o] << 12) + (d << 7) + opc;
      3: word = (fld(im, 11, 5) << 25) + (s2 << 20) + (s1 << 15) + (o << 12)
                + (fld(im, 4, 0) << 7) + opc;
      4: word = (fld(im, 12, 12) << 31) + (fld(im, 10, 5) << 25) + (s2 << 20) + (s1 << 15)
                + (br_f3[o] << 12) + (fld(im, 4, 1) << 8) + (fld(im, 11, 11) << 7) + opc;
      5: word = (fld(im, 20, 20) << 31) + (fld(im, 10, 1) << 21) + (fld(im, 11, 11) << 20)
                + (fld(im, 19, 12) << 12) + (d << 7) + opc;
      6: word = (fld(im, 11, 0) << 20) + (s1 << 15) + (d << 7) + opc;
      default: word = (im & 32'hFFFFF000) + (d << 7) + opc;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_instr = '0;
    m_err = 0;
    m_count = 0;
  endtask

  // One cycle: drive at the falling edge, advance the model at the rising
  // edge, compare at the next falling edge.
  task automatic apply_stimulus(input bit v, input int c, input int o, input int d,
                                input int s1, input int s2, input logic [31:0] im,
                                input bit rdy);
    bit legal;
    bit acc;
    bit drain;
    logic [31:0] word;
    in_valid = v; cls = 4'(c); op = 4'(o); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    imm = im; down_ready = rdy;
    ref_encode(c, o, d, s1, s2, im, legal, word);
    #1;
    check_output("ready", {31'd0, out_ready}, {31'd0, !m_valid || rdy});
    @(posedge clk);
    acc = v && (!m_valid || rdy);
    drain = m_valid && rdy;
    if (drain && m_count < 'hFFFF) m_count++;
    m_err = acc && !legal;
    if (acc && legal) begin
      m_valid = 1;
      m_instr = word;
    end else if (drain) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_output("valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_output("err", {31'd0, err}, {31'd0, m_err});
    check_output("count", {16'd0, count}, 32'(m_count));
    if (m_valid) check_output("instr", instr, m_instr);
  endtask

  initial begin
    int saved;
    int rc;
    int ro;
    int mode;
    logic [31:0] rimm;
    rst_n = 1'b0; in_valid = 0; cls = '0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
    imm = '0; down_ready = 0;
    model_reset();
    #3;
    check_output("rst_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_err", {31'd0, err}, 32'd0);
    check_output("rst_instr", instr, 32'd0);
    check_output("rst_count", {16'd0, count}, 32'd0);
    check_output("rst_ready", {31'd0, out_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal R op, then a four-word stream.
    apply_stimulus(1, 0, 10, 3, 1, 2, 0, 1);
    check_output("illegal_op_err", {31'd0, err}, 32'd1);
    check_output("illegal_op_valid", {31'd0, out_valid}, 32'd0);
    apply_stimulus(1, 0, 0, 3, 1, 2, 0, 1);
    check_output("err_one_cycle", {31'd0, err}, 32'd0);
    apply_stimulus(1, 0, 5, 4, 1, 2, 0, 1);
    apply_stimulus(1, 1, 0, 6, 7, 0, 32'h7FF, 1);
    apply_stimulus(1, 2, 2, 8, 9, 0, 32'h10, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    check_output("stream_count", {16'd0, count}, 32'd4);

    // Directed encodings.
    apply_stimulus(1, 0, 0, 3, 1, 2, 0, 1);
    check_output("add_word", instr, 32'h002081B3);
    apply_stimulus(1, 1, 6, 5, 6, 0, 3, 1);
    check_output("srai_word", instr, 32'h40335293);
    apply_stimulus(1, 7, 0, 10, 0, 0, 32'h12345000, 1);
    check_output("lui_word", instr, 32'h12345537);
    apply_stimulus(1, 4, 0, 0, 1, 2, 32'hFFFFFFFC, 1);
    check_output("beq_word", instr, 32'hFE208EE3);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    saved = int'(count);
    apply_stimulus(1, 4, 0, 0, 1, 2, 32'hFFFFFFFD, 1);
    check_output("beq_odd_err", {31'd0, err}, 32'd1);
    check_output("beq_odd_valid", {31'd0, out_valid}, 32'd0);
    check_output("beq_odd_count", {16'd0, count}, 32'(saved));
    apply_stimulus(1, 1, 1, 5, 6, 0, 32'h20, 1);
    check_output("shift_imm_err", {31'd0, err}, 32'd1);

    // Backpressure: held word stays put, next request waits.
    apply_stimulus(1, 0, 0, 3, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 1, 3, 1, 2, 0, 0);
      check_output("hold_instr", instr, 32'h002081B3);
    end
    saved = int'(count);
    apply_stimulus(1, 0, 1, 3, 1, 2, 0, 1);
    check_output("after_hold_count", {16'd0, count}, 32'(saved + 1));
    check_output("after_hold_word", instr, 32'h402081B3);

    // Asynchronous reset with a held word and count of five.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(1, 3, i % 3, 0, i, i + 1, 32'(i * 4), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(1, 6, 0, 1, 2, 0, 32'h123, 0);
    check_output("pre_rst_count", {16'd0, count}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("async_valid", {31'd0, out_valid}, 32'd0);
    check_output("async_count", {16'd0, count}, 32'd0);
    check_output("async_instr", instr, 32'd0);
    check_output("async_ready", {31'd0, out_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 5, 0, 1, 0, 0, 32'h800, 1);
    check_output("first_accept_valid", {31'd0, out_valid}, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rc = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 15));
      if (rc <= 8 && $urandom_range(0, 9) != 0) ro = int'($urandom_range(0, nops[rc] - 1));
      else ro = int'($urandom_range(0, 15));
      rimm = $urandom;
      mode = int'($urandom_range(0, 3));
      if (mode == 1) rimm = rimm & 32'h1F;
      else if (mode == 2) rimm = rimm & 32'hFFFFFFFE;
      else if (mode == 3) rimm = rimm & 32'hFFE;
      apply_stimulus($urandom_range(0, 3) != 0, rc, ro, int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rimm,
                     $urandom_range(0, 9) < 7);
    end

    // Saturation: stream enough words to pin the counter at its ceiling.
    in_valid = 1; cls = 4'd0; op = 4'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0;
    down_ready = 1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    m_valid = 1; m_instr = 32'h002081B3; m_err = 0; m_count = 'hFFFF;
    check_output("sat_count", {16'd0, count}, 32'h0000FFFF);
    apply_stimulus(1, 0, 0, 3, 1, 2, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    check_output("sat_hold", {16'd0, count}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
